// File: rtl/result_pkg.sv
// Shared types for the result collector: entry layout and flag bit positions.
package result_pkg;

    localparam int RESULT_W  = 8;
    localparam int FLAGS_W   = 4;
    localparam int CORE_ID_W = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [CORE_ID_W-1:0] core_id;
        logic [FLAGS_W-1:0]   flags;
        logic [RESULT_W-1:0]  result;
    } result_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from i_ptr upward (mod N), grants first requester.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Round-robin result collector with core-tagged FWFT FIFO.
// Optional push statistics enabled by RESULT_COLLECTOR_STATS_EN.
module result_collector
    import result_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 8,
    parameter int CORE_W    = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          in_valid,
    input  logic [NUM_CORES*RESULT_W-1:0] in_result,
    input  logic [NUM_CORES*FLAGS_W-1:0]  in_flags,
    output logic [NUM_CORES-1:0]          in_ready,
    output logic                          out_valid,
    output logic [RESULT_W-1:0]           out_result,
    output logic [FLAGS_W-1:0]            out_flags,
    output logic [CORE_W-1:0]             out_core,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
`ifdef RESULT_COLLECTOR_STATS_EN
    output logic [15:0]                   stat_total,
    output logic [15:0]                   stat_zero,
`endif
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    result_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CORE_W-1:0]    r_rr_ptr;

    logic [NUM_CORES-1:0] w_grant;
    logic [CORE_W-1:0]    w_gnt_idx;
    logic                 w_push;
    logic                 w_pop;
    result_entry_t        w_wr_entry;
    result_entry_t        w_head;
    logic                 w_unused;

    rr_arbiter #(
        .N (NUM_CORES),
        .W (CORE_W)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx)
    );

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // No write-through: a full FIFO refuses even when the head pops this cycle.
    assign in_ready = (reset || full) ? '0 : w_grant;
    assign w_push   = |(in_valid & in_ready);
    assign w_pop    = out_valid && out_ready;

    always_comb begin
        w_wr_entry         = '0;
        w_wr_entry.core_id = CORE_ID_W'(w_gnt_idx);
        w_wr_entry.flags   = in_flags[w_gnt_idx*FLAGS_W +: FLAGS_W];
        w_wr_entry.result  = in_result[w_gnt_idx*RESULT_W +: RESULT_W];
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = !empty;
    assign out_result = w_head.result;
    assign out_flags  = w_head.flags;
    assign out_core   = w_head.core_id[CORE_W-1:0];
    assign w_unused   = ^w_head.core_id;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (int'(w_gnt_idx) == NUM_CORES - 1)
                            ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RESULT_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total <= '0;
            stat_zero  <= '0;
        end else if (w_push) begin
            if (stat_total != 16'hFFFF) begin
                stat_total <= stat_total + 1'b1;
            end
            if (w_wr_entry.flags[FLAG_Z] && stat_zero != 16'hFFFF) begin
                stat_zero <= stat_zero + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed + randomized bench for result_collector against a queue-based model.
module tb_result_collector;

    localparam int NC = 4;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   in_valid;
    logic [NC*8-1:0] in_result;
    logic [NC*4-1:0] in_flags;
    logic [NC-1:0]   in_ready;
    logic            out_valid;
    logic [7:0]      out_result;
    logic [3:0]      out_flags;
    logic [1:0]      out_core;
    logic            out_ready;
    logic [3:0]      count;
    logic            full;
    logic            empty;
`ifdef RESULT_COLLECTOR_STATS_EN
    logic [15:0]     stat_total;
    logic [15:0]     stat_zero;
`endif

    result_collector #(.NUM_CORES(NC), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_core   (out_core),
        .out_ready  (out_ready),
        .count      (count),
        .full       (full),
`ifdef RESULT_COLLECTOR_STATS_EN
        .stat_total (stat_total),
        .stat_zero  (stat_zero),
`endif
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        int flg;
        int core;
    } ent_t;

    ent_t q[$];
    int   rr = 0;
    int   st_total = 0;
    int   st_zero = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant_idx();
        if (reset || q.size() == D) return -1;
        for (int k = 0; k < NC; k++) begin
            if (in_valid[(rr + k) % NC]) return (rr + k) % NC;
        end
        return -1;
    endfunction

    // Check all outputs against the model, then advance one clock.
    task automatic cycle();
        int g;
        logic [NC-1:0] gv;
        #1;
        g  = exp_grant_idx();
        gv = '0;
        if (g >= 0) gv[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(gv));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == D));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        if (q.size() != 0) begin
            chk("out_result", 32'(out_result), 32'(q[0].res));
            chk("out_flags", 32'(out_flags), 32'(q[0].flg));
            chk("out_core", 32'(out_core), 32'(q[0].core));
        end
`ifdef RESULT_COLLECTOR_STATS_EN
        chk("stat_total", 32'(stat_total), 32'(st_total));
        chk("stat_zero", 32'(stat_zero), 32'(st_zero));
`endif
        @(posedge clk);
        if (reset) begin
            q.delete();
            rr = 0;
            st_total = 0;
            st_zero = 0;
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{int'(in_result[g*8 +: 8]),
                              int'(in_flags[g*4 +: 4]), g});
                rr = (g + 1) % NC;
                if (st_total < 65535) st_total++;
                if (in_flags[g*4] && st_zero < 65535) st_zero++;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_data();
        in_result = NC*8'($urandom);
        in_flags  = NC*4'($urandom);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_result = '0;
        in_flags  = '0;
        out_ready = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        // Single push from core 2
        @(negedge clk);
        in_valid = 4'b0100;
        in_result[2*8 +: 8] = 8'h3C;
        in_flags[2*4 +: 4]  = 4'b0001;
        #1;
        chk("single_rdy", 32'(in_ready), 32'h4);
        cycle();
        in_valid = '0;
        #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_res", 32'(out_result), 32'h3C);
        chk("single_core", 32'(out_core), 32'd2);
        chk("single_cnt", 32'(count), 32'd1);
        cycle();

        // Fairness: all cores valid into a freshly reset FIFO
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = '1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            #1;
            chk("fair_grant", 32'(in_ready), 32'(1 << (i % 4)));
            cycle();
        end
        #1;
        chk("fair_full", 32'(full), 32'd1);
        chk("fair_block", 32'(in_ready), 32'd0);
        cycle();

        // Pop while full: no push that cycle, refill the next
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        #1;
        chk("fp_cnt7", 32'(count), 32'd7);
        chk("fp_ready", 32'(in_ready), 32'h1);
        cycle();
        #1;
        chk("fp_cnt8", 32'(count), 32'd8);
        cycle();

        // Simultaneous push/pop at occupancy 3 with pointer wrap
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 4'b1 << $urandom_range(0, 3);
            rand_data();
            #1;
            chk("pp_cnt", 32'(count), 32'd3);
            cycle();
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = NC'($urandom);
            out_ready = ($urandom_range(0, 3) != 0) ^ (i[6]);
            rand_data();
            cycle();
        end
        reset = 1'b0;

`ifdef RESULT_COLLECTOR_STATS_EN
        reset = 1'b1;
        cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            in_flags[0] = (i == 1 || i == 3);
            cycle();
        end
        in_valid = '0;
        #1;
        chk("st_total5", 32'(stat_total), 32'd5);
        chk("st_zero2", 32'(stat_zero), 32'd2);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk("st_total0", 32'(stat_total), 32'd0);
        chk("st_zero0", 32'(stat_zero), 32'd0);
        chk("st_empty", 32'(empty), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream consumer of the per-core `result[7:0]`/`flags[3:0]` outputs in the multiprocessor top level.
- Arbitrates between NUM_CORES producers using fair round-robin.
- Tags each accepted result with its core ID and buffers it in a FIFO.
- Presents buffered entries to a single consumer (display/UART/host stage) over a valid/ready interface.

Parameters:
- NUM_CORES, 4, number of producing cores (2..8).
- DEPTH, 8, FIFO entries (power of two, ≥2).
- CORE_W, $clog2(NUM_CORES), width of the core-ID tag.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CORES  per-core result available.
- in_result  in  NUM_CORES*8  packed results; core i occupies [i*8+:8].
- in_flags  in  NUM_CORES*4  packed flags; core i occupies [i*4+:4].
- in_ready  out  NUM_CORES  one-hot accept strobe per core.
- out_valid  out  1  FIFO head valid.
- out_result  out  8  head result.
- out_flags  out  4  head flags.
- out_core  out  CORE_W  head source core.
- out_ready  in  1  consumer accepts head.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset, sampled on posedge: rd_ptr=wr_ptr=0, count=0, rr_ptr=0. Resulting outputs: out_valid=0, in_ready=0, full=0, empty=1. Memory contents are not cleared.
- Reset mid-operation discards all buffered entries. in_ready is forced to 0 while reset=1.
- Arbitration (combinational):
  - Search order starts at rr_ptr, then rr_ptr+1, … mod NUM_CORES.
  - The first core with in_valid=1 is granted.
  - in_ready = grant one-hot when !full, else 0.
  - At most one push per cycle.
- Push occurs when |(in_valid & in_ready).
  - Write {core_id, flags, result} at wr_ptr; wr_ptr += 1 with wrap at DEPTH.
  - rr_ptr ← granted index + 1 mod NUM_CORES.
  - rr_ptr is held when there is no push.
- Pop occurs when out_valid && out_ready; rd_ptr += 1 with wrap.
- First-word fall-through output:
  - out_valid = !empty.
  - out_* driven combinationally from mem[rd_ptr].
  - A push into an empty FIFO is visible on out_valid in the next cycle (latency 1).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, in_ready=0 even if a pop occurs that cycle. There is no write-through on a full FIFO.
- When empty, out_ready is ignored and no pointer moves.
- Producers must hold in_valid and data stable until in_ready is seen. Deasserting in_valid early is legal; the entry is then simply not captured.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is tracked separately, from 0 to DEPTH.

Optional Feature:
- Macro RESULT_COLLECTOR_STATS_EN.
- When defined:
  - Extra outputs stat_total[15:0] and stat_zero[15:0].
  - Both increment on each push; stat_zero increments only when pushed flags[FLAG_Z]=1.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When undefined: the ports and counters are absent and area is unchanged.

Decomposition:
- Package result_pkg holds:
  - RESULT_W=8, FLAGS_W=4.
  - Flag indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3.
  - Packed entry typedef result_entry_t {core_id, flags, result}.
- Sub-module rr_arbiter (request vector, rr_ptr → one-hot grant plus index) instantiated once.
- FIFO storage and control stay in the top module.

Test Plan:
- Reset held 2 cycles, then released → empty=1, out_valid=0, in_ready=0, count=0.
- Single push: core2 valid with result=8'h3C, flags=4'b0001, out_ready=0 → in_ready=4'b0100; next cycle out_valid=1, out_result=8'h3C, out_core=2, count=1.
- Fairness: all 4 cores valid continuously for 8 cycles, DEPTH=8, out_ready=0 → grant order 0,1,2,3,0,1,2,3; full=1 after cycle 8; in_ready=0 thereafter.
- Full plus pop: while full, keep in_valid=1 and pulse out_ready for 1 cycle → no push that cycle, count 8→7; the following cycle push is accepted and count=8.
- Simultaneous push/pop at count=3 → count stays 3; output order preserved FIFO; wrap past index 7 verified over 20 transfers.
- With RESULT_COLLECTOR_STATS_EN: push 5 results, 2 with flags[0]=1 → stat_total=5, stat_zero=2; reset mid-run → both 0 and FIFO empty.
